// File: rtl/lr_shift_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lr_shift_pipe: pipelined logical/arithmetic/rotate left/right shifter    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lr_shift_pipe #(
  parameter  int WIDTH = 8,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_bits,
  input  logic [SW:0]      i_shift,
  input  logic             i_dir,
  input  logic [1:0]       i_mode,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] o_bits,
  output logic             o_valid,
  input  logic             o_ready
);

  localparam logic       c_dir_left     = 1'b0;
  localparam logic       c_dir_right    = 1'b1;
  localparam logic [1:0] c_mode_logical = 2'd0;
  localparam logic [1:0] c_mode_arith   = 2'd1;
  localparam logic [1:0] c_mode_rotate  = 2'd2;

  logic [WIDTH-1:0] r_bits  [SW];
  logic [SW:0]      r_shift [SW];
  logic             r_dir   [SW];
  logic [1:0]       r_mode  [SW];
  logic             r_sign  [SW];
  logic [SW-1:0]    r_valid;

  logic [WIDTH-1:0] w_up_bits  [SW];
  logic [SW:0]      w_up_shift [SW];
  logic             w_up_dir   [SW];
  logic [1:0]       w_up_mode  [SW];
  logic             w_up_sign  [SW];
  logic [SW-1:0]    w_up_valid;
  logic [WIDTH-1:0] w_nxt_bits [SW];
  logic [SW-1:0]    w_load;

  function automatic logic [WIDTH-1:0] f_shift_step(
    input logic [WIDTH-1:0] bits,
    input int               amt,
    input logic             dir,
    input logic [1:0]       mode,
    input logic             sign
  );
    logic [WIDTH-1:0] res;
    case (mode)
      c_mode_rotate:
        res = (dir == c_dir_left) ? ((bits << amt) | (bits >> (WIDTH - amt)))
                                  : ((bits >> amt) | (bits << (WIDTH - amt)));
      c_mode_arith:
        res = (dir == c_dir_right) ? WIDTH'({{WIDTH{sign}}, bits} >> amt)
                                   : (bits << amt);
      c_mode_logical:
        res = (dir == c_dir_left) ? (bits << amt) : (bits >> amt);
      default:
        res = (dir == c_dir_left) ? (bits << amt) : (bits >> amt);
    endcase
    return res;
  endfunction

  // A stage can load when it or any stage below it is empty, or the output is taken.
  for (genvar k = 0; k < SW; k++) begin : g_load
    assign w_load[k] = o_ready || !(&r_valid[SW-1:k]);
  end

  assign i_ready = rst && w_load[0];
  assign o_bits  = r_bits[SW-1];
  assign o_valid = r_valid[SW-1];

  always_comb begin
    w_up_bits[0]  = i_bits;
    w_up_shift[0] = i_shift;
    w_up_dir[0]   = i_dir;
    w_up_mode[0]  = i_mode;
    w_up_sign[0]  = i_bits[WIDTH-1];
    w_up_valid[0] = i_valid;
    for (int k = 1; k < SW; k++) begin
      w_up_bits[k]  = r_bits[k-1];
      w_up_shift[k] = r_shift[k-1];
      w_up_dir[k]   = r_dir[k-1];
      w_up_mode[k]  = r_mode[k-1];
      w_up_sign[k]  = r_sign[k-1];
      w_up_valid[k] = r_valid[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < SW; k++) begin
      w_nxt_bits[k] = w_up_shift[k][k]
                    ? f_shift_step(w_up_bits[k], 1 << k, w_up_dir[k], w_up_mode[k], w_up_sign[k])
                    : w_up_bits[k];
      // Saturation for shifts of width or more; rotate ignores the top shift bit.
      if ((k == SW - 1) && w_up_shift[k][SW] && (w_up_mode[k] != c_mode_rotate)) begin
        w_nxt_bits[k] = ((w_up_mode[k] == c_mode_arith) && (w_up_dir[k] == c_dir_right))
                      ? {WIDTH{w_up_sign[k]}} : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SW; k++) begin
        r_bits[k]  <= '0;
        r_shift[k] <= '0;
        r_dir[k]   <= 1'b0;
        r_mode[k]  <= 2'd0;
        r_sign[k]  <= 1'b0;
      end
      r_valid <= '0;
    end else begin
      for (int k = 0; k < SW; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= w_up_valid[k];
          if (w_up_valid[k]) begin
            r_bits[k]  <= w_nxt_bits[k];
            r_shift[k] <= w_up_shift[k];
            r_dir[k]   <= w_up_dir[k];
            r_mode[k]  <= w_up_mode[k];
            r_sign[k]  <= w_up_sign[k];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lr_shift_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lr_shift_pipe: scoreboard bench for lr_shift_pipe (widths 8 and 16)   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_lr_shift_pipe;

  localparam logic       c_left  = 1'b0;
  localparam logic       c_right = 1'b1;
  localparam logic [1:0] c_log   = 2'd0;
  localparam logic [1:0] c_ari   = 2'd1;
  localparam logic [1:0] c_rot   = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  i_bits8;  logic [3:0] i_shift8;  logic i_dir8;  logic [1:0] i_mode8;
  logic        i_valid8, i_ready8, o_valid8, o_ready8;
  logic [7:0]  o_bits8;
  logic [15:0] i_bits16; logic [4:0] i_shift16; logic i_dir16; logic [1:0] i_mode16;
  logic        i_valid16, i_ready16, o_valid16, o_ready16;
  logic [15:0] o_bits16;

  lr_shift_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .i_bits(i_bits8), .i_shift(i_shift8), .i_dir(i_dir8),
    .i_mode(i_mode8), .i_valid(i_valid8), .i_ready(i_ready8), .o_bits(o_bits8),
    .o_valid(o_valid8), .o_ready(o_ready8));

  lr_shift_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .i_bits(i_bits16), .i_shift(i_shift16), .i_dir(i_dir16),
    .i_mode(i_mode16), .i_valid(i_valid16), .i_ready(i_ready16), .o_bits(o_bits16),
    .o_valid(o_valid16), .o_ready(o_ready16));

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  q8  [$];
  logic [15:0] q16 [$];
  int          held8 = 0;
  logic        saw_stall = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bit-serial reference: one single-bit step per unit of shift.
  function automatic logic [15:0] ref16(input logic [15:0] b, input int sh,
                                        input logic d, input logic [1:0] m);
    logic [15:0] r;
    logic        s;
    int          n;
    r = b;
    s = b[15];
    n = (m == c_rot) ? (sh % 16) : sh;
    for (int i = 0; i < n; i++) begin
      if (d == c_left) r = {r[14:0], (m == c_rot) ? r[15] : 1'b0};
      else             r = {(m == c_rot) ? r[0] : ((m == c_ari) ? s : 1'b0), r[15:1]};
    end
    return r;
  endfunction

  // Output monitors: pop the scoreboard whenever a result is taken.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst && o_valid8 && o_ready8) begin
      n_cmp++;
      if (q8.size() == 0) begin
        n_bad++;
        $display("FAIL out8: actual=%h required=<no result expected>", o_bits8);
      end else begin
        e = q8.pop_front();
        if (o_bits8 !== e) begin
          n_bad++;
          $display("FAIL out8: actual=%h required=%h", o_bits8, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    if (rst && o_valid16 && o_ready16) begin
      n_cmp++;
      if (q16.size() == 0) begin
        n_bad++;
        $display("FAIL out16: actual=%h required=<no result expected>", o_bits16);
      end else begin
        e = q16.pop_front();
        if (o_bits16 !== e) begin
          n_bad++;
          $display("FAIL out16: actual=%h required=%h", o_bits16, e);
        end
      end
    end
  end

  // i_ready model: ready unless all three stages hold data and the output is stalled.
  always @(negedge clk) begin
    if (!rst) begin
      held8 = 0;
      chk("i_ready8 in reset", 32'(i_ready8), 0);
    end else begin
      chk("i_ready8 flow", 32'(i_ready8), 32'((held8 < 3) || o_ready8));
      if (i_valid8 && !i_ready8) saw_stall = 1'b1;
      if (i_valid8 && i_ready8) held8++;
      if (o_valid8 && o_ready8) held8--;
    end
  end

  task automatic send8(input logic [7:0] b, input logic [3:0] sh, input logic d,
                       input logic [1:0] m, input logic [7:0] exp);
    int t;
    t = 0;
    @(posedge clk); #1;
    i_bits8 = b; i_shift8 = sh; i_dir8 = d; i_mode8 = m; i_valid8 = 1'b1;
    @(negedge clk);
    while (!i_ready8 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (i_ready8) q8.push_back(exp);
    else chk("send8 accept timeout", 0, 1);
  endtask

  task automatic idle8();
    @(posedge clk); #1;
    i_valid8 = 1'b0;
  endtask

  task automatic drain8();
    int t;
    t = 0;
    while (q8.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain8 leftover", q8.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent, cyc;
    logic v;
    i_bits8 = '0; i_shift8 = '0; i_dir8 = 1'b0; i_mode8 = 2'd0; i_valid8 = 1'b0; o_ready8 = 1'b1;
    i_bits16 = '0; i_shift16 = '0; i_dir16 = 1'b0; i_mode16 = 2'd0; i_valid16 = 1'b0; o_ready16 = 1'b1;

    #2 rst = 1'b0;
    #1;
    chk("reset o_valid", 32'(o_valid8), 0);
    chk("reset o_bits", 32'(o_bits8), 0);
    chk("reset i_ready", 32'(i_ready8), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("i_ready after release", 32'(i_ready8), 1);

    // Latency: accept edge N, o_valid visible after edge N+2.
    send8(8'h96, 4'd3, c_left, c_log, 8'hB0);
    idle8();
    @(negedge clk) chk("latency after N", 32'(o_valid8), 0);
    @(negedge clk) chk("latency after N+1", 32'(o_valid8), 0);
    @(negedge clk) chk("latency after N+2", 32'(o_valid8), 1);
    drain8();

    // Directed vectors, back to back.
    send8(8'h96, 4'd2,  c_right, c_ari, 8'hE5);
    send8(8'h96, 4'd3,  c_right, c_rot, 8'hD2);
    send8(8'h96, 4'd9,  c_left,  c_rot, 8'h2D);
    send8(8'h96, 4'd8,  c_right, c_rot, 8'h96);
    send8(8'h96, 4'd8,  c_left,  c_rot, 8'h96);
    send8(8'h96, 4'd8,  c_left,  c_log, 8'h00);
    send8(8'h96, 4'd8,  c_right, c_ari, 8'hFF);
    send8(8'h46, 4'd15, c_right, c_ari, 8'h00);
    send8(8'h96, 4'd4,  c_right, c_log, 8'h09);
    send8(8'h96, 4'd2,  c_left,  c_ari, 8'h58);
    send8(8'h96, 4'd0,  c_right, c_ari, 8'h96);
    send8(8'h96, 4'd15, c_left,  c_rot, 8'h4B);
    send8(8'h96, 4'd7,  c_right, c_ari, 8'hFF);
    send8(8'h46, 4'd1,  c_right, c_ari, 8'h23);
    send8(8'h96, 4'd15, c_right, c_log, 8'h00);
    idle8();
    drain8();

    // Back-pressure: six transfers with the consumer stalled for five cycles.
    saw_stall = 1'b0;
    fork
      begin
        send8(8'h01, 4'd1, c_left, c_log, 8'h02);
        send8(8'h02, 4'd1, c_left, c_log, 8'h04);
        send8(8'h03, 4'd1, c_left, c_log, 8'h06);
        send8(8'h04, 4'd1, c_left, c_log, 8'h08);
        send8(8'h05, 4'd1, c_left, c_log, 8'h0A);
        send8(8'h06, 4'd1, c_left, c_log, 8'h0C);
        idle8();
      end
      begin
        repeat (3) @(posedge clk);
        #1 o_ready8 = 1'b0;
        repeat (5) @(posedge clk);
        #1 o_ready8 = 1'b1;
      end
    join
    drain8();
    chk("back-pressure stall seen", 32'(saw_stall), 1);

    // Reset with two transactions in flight.
    o_ready8 = 1'b0;
    send8(8'h11, 4'd1, c_left, c_log, 8'h22);
    send8(8'h22, 4'd1, c_left, c_log, 8'h44);
    idle8();
    @(posedge clk);
    @(negedge clk) chk("held before reset", 32'(o_valid8), 1);
    #2 rst = 1'b0;
    q8.delete();
    #1;
    chk("o_valid async clear", 32'(o_valid8), 0);
    chk("i_ready async clear", 32'(i_ready8), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    o_ready8 = 1'b1;
    repeat (4) @(negedge clk) chk("o_valid after flush", 32'(o_valid8), 0);
    send8(8'h96, 4'd2, c_right, c_ari, 8'hE5);
    idle8();
    drain8();

    // Randomised sweep on the 16-bit instance.
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      v = ($urandom_range(0, 3) != 0);
      i_valid16 = v;
      i_bits16  = 16'($urandom);
      i_shift16 = 5'($urandom_range(0, 31));
      i_dir16   = 1'($urandom_range(0, 1));
      i_mode16  = 2'($urandom_range(0, 2));
      o_ready16 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (i_valid16 && i_ready16) begin
        q16.push_back(ref16(i_bits16, int'(i_shift16), i_dir16, i_mode16));
        sent++;
      end
      cyc++;
    end
    chk("sweep transactions issued", sent, 10000);
    @(posedge clk); #1;
    i_valid16 = 1'b0;
    o_ready16 = 1'b1;
    cyc = 0;
    while (q16.size() != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain16 leftover", q16.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lr_shift_pipe.md
# lr_shift_pipe

Pipelined, multi-mode left/right bit shifter. It generalises the direct left/right shifter composition in three ways: logical, arithmetic and rotate modes; an extended shift range with saturation; and a registered logarithmic pipeline with valid/ready flow control. It sits in the datapath between a streaming producer and consumer, and each transaction carries its own operand, shift amount, direction and mode.

## Interface
Parameters:
- `width`, default 8: operand width in bits. Must be a power of 2 and ≥ 2. `SW = clog2(width)`.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, asynchronous and active-low.
- `i_bits`, in, `width`: operand.
- `i_shift`, in, `SW+1`: shift amount, 0..2·width−1.
- `i_dir`, in, `ShiftDir`: `Left` or `Right`.
- `i_mode`, in, `ShiftMode`: `Logical`, `Arith` or `Rotate`.
- `i_valid`, in, 1: input transaction present.
- `i_ready`, out, 1: block accepts the input this cycle.
- `o_bits`, out, `width`: result.
- `o_valid`, out, 1: result present.
- `o_ready`, in, 1: consumer accepts the result.

## Operation
- A transfer occurs on `i_valid && i_ready` (input side) and on `o_valid && o_ready` (output side), sampled at the rising edge of `clk`.
- The pipeline has `SW` register stages, S0..S(SW−1).
  - Stage k applies a shift of 2^k when `i_shift[k]` is 1.
  - Stage SW−1 also applies the out-of-range rule, driven by `i_shift[SW]`.
  - Each stage carries bits, remaining shift bits, dir, mode and a valid flag.
- Logical mode: vacated bits are filled with 0.
- Arith mode, Right: vacated bits are filled with the operand MSB, captured at S0.
- Arith mode, Left: identical to Logical Left.
- Rotate mode: the shift amount is taken mod `width`, so `i_shift[SW]` is ignored. Rotate Left moves the MSB into the LSB; Rotate Right moves the LSB into the MSB.
- Out-of-range rule (non-rotate, `i_shift ≥ width`):
  - Logical, or Arith Left: result is all 0.
  - Arith Right: result is all copies of the sign bit.
- `i_shift = 0`: the result equals `i_bits` in every mode and direction.
- Flow control:
  - Stage k loads from its upstream when (stage k is empty) OR (stage k+1 loads this cycle). For the last stage, "stage k+1 loads" means "output is taken".
  - `i_ready` = S0 can load.
  - Bubbles collapse, so the pipeline holds up to `SW` transactions.
- A stalled stage holds all its contents. No transaction is dropped, duplicated or reordered.
- `o_bits` and `o_valid` come straight from the last-stage registers.
- `o_bits` is held while `o_valid && !o_ready`.
- `o_bits` is don't-care when `o_valid` = 0; the implementation keeps its last value.

## Timing
- Latency: a transaction accepted at edge N appears with `o_valid` = 1 after edge N+SW−1 (width 8: visible in the cycle after the 3rd edge, counting the accept edge), provided there is no stall.
- Throughput: one transaction per cycle while `o_ready` = 1.
- Reset (`rst` low, asynchronous):
  - All stage valid flags and `o_valid` clear immediately.
  - `o_bits` and stage data go to 0.
  - `i_ready` is 0 while `rst` is low.
- After `rst` is released, `i_ready` = 1 from the first clock cycle.
- Reset asserted mid-operation flushes every in-flight transaction. None of them appear after release.
- Full pipeline with `o_ready` = 0: `i_ready` = 0.
- Simultaneous output take and input accept on a full pipeline: all stages advance in the same edge, `i_ready` = 1, and there is no bubble.
- `i_ready` depends combinationally on `o_ready` through the valid chain. This path contains no datapath logic.

## Test plan
- Logical and arithmetic shifts, width=8:
  - 0x96, Left, Logical, shift 3 → 0xB0, `o_valid` on the 3rd cycle after accept.
  - 0x96, Right, Arith, shift 2 → 0xE5.
- Rotate, width=8:
  - 0x96, Right, Rotate, shift 3 → 0xD2.
  - 0x96, Left, Rotate, shift 9 → 0x2D (mod 8).
  - 0x96, Rotate, shift 8 → 0x96.
- Out-of-range, width=8:
  - 0x96, shift 8, Logical Left → 0x00.
  - 0x96, shift 8, Arith Right → 0xFF.
  - 0x46, shift 15, Arith Right → 0x00.
- Back-pressure:
  - Stimulus: stream 6 back-to-back transactions (0x01..0x06, Left Logical shift 1), with `o_ready` low for cycles 4–8.
  - Required response:
    - `i_ready` drops once 3 transactions are held.
    - Outputs are 0x02, 0x04, 0x06, 0x08, 0x0A, 0x0C, in order, with none lost.
    - No bubble is created when `o_ready` returns.
- Reset mid-stream:
  - Stimulus: assert `rst` low between clock edges with 2 transactions in flight.
  - Required response:
    - `o_valid` falls immediately, without waiting for a clock edge.
    - After release, `o_valid` stays 0 until a new accept.
    - The next transaction produces the correct result.
- Randomised sweep, width=16:
  - Stimulus: random operands, shifts 0..31, all dir/mode combinations, random `i_valid`/`o_ready`.
  - Required response: scoreboard against a reference model, with zero mismatches over 10k transactions.
